// File: rtl/rename_regfile.sv
// ---------------------------------------------------------------------------
// rename_regfile
//
// Register file with a rename (busy/tag) table for an out-of-order core.
// Each architectural register holds its committed value, a busy bit that
// says a younger in-flight instruction will produce it, and the ROB
// position (tag) of that producer. Source lookups are combinational.
// When a commit retires the producer a lookup is naming, the lookup is
// bypassed to the committing value.
//
// Optional branch checkpoints take snapshots of the busy/tag table in a
// circular buffer. A snapshot can be released (branch resolved correctly)
// or restored (mispredict). Build with RENAME_RF_CKPT_EN defined to
// include them. Without that macro, no snapshot storage exists, the ckpt_*
// inputs are ignored, and recovery uses the rollback input only.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   rdy                global enable, 0 freezes every piece of state
//   rollback           full flush: nothing busy, every checkpoint freed
//   q_rs/q_val/q_busy/q_tag   RD_PORTS flattened source lookup ports
//   issue, issue_rd, issue_tag                 rename rd to a ROB tag
//   commit, commit_rd, commit_val, commit_tag  retire a result
//   ckpt_take, ckpt_release                    snapshot / free oldest
//   ckpt_restore, ckpt_restore_id              mispredict recovery
//   ckpt_id            id that the next take will receive
//   ckpt_full          every checkpoint slot is live
// ---------------------------------------------------------------------------
module rename_regfile #(
   parameter int DATA_W   = 32,
   parameter int REG_N    = 32,
   parameter int ROB_W    = 4,
   parameter int RD_PORTS = 2,
   parameter int CKPT_N   = 4,
   localparam int REG_W   = $clog2(REG_N),
   localparam int CK_W    = $clog2(CKPT_N)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       rollback,
   input  logic [RD_PORTS*REG_W-1:0]  q_rs,
   output logic [RD_PORTS*DATA_W-1:0] q_val,
   output logic [RD_PORTS-1:0]        q_busy,
   output logic [RD_PORTS*ROB_W-1:0]  q_tag,
   input  logic                       issue,
   input  logic [REG_W-1:0]           issue_rd,
   input  logic [ROB_W-1:0]           issue_tag,
   input  logic                       commit,
   input  logic [REG_W-1:0]           commit_rd,
   input  logic [DATA_W-1:0]          commit_val,
   input  logic [ROB_W-1:0]           commit_tag,
   input  logic                       ckpt_take,
   input  logic                       ckpt_release,
   input  logic                       ckpt_restore,
   input  logic [CK_W-1:0]            ckpt_restore_id,
   output logic [CK_W-1:0]            ckpt_id,
   output logic                       ckpt_full
);

   logic [DATA_W-1:0] val_q [REG_N];
   logic [REG_N-1:0]  busy_q;
   logic [ROB_W-1:0]  tag_q [REG_N];

   logic [REG_N-1:0]  busy_upd;
   logic [ROB_W-1:0]  tag_upd [REG_N];

   logic              commit_ok;
   logic              commit_hit;
   logic              issue_ok;

   logic              restore_ok;
   logic [REG_N-1:0]  rest_busy;
   logic [ROB_W-1:0]  rest_tag [REG_N];

   // Register 0 is hardwired. Its entry is never written, so it reads as
   // zero after reset. commit_hit means the commit retires the producer
   // that the rename table currently names for commit_rd.
   assign commit_ok  = commit && (commit_rd != '0);
   assign commit_hit = commit_ok && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);
   assign issue_ok   = issue && (issue_rd != '0);

   // Rename table after this cycle's commit and issue. The issue is applied
   // last, so a new rename of rd beats a commit that would clear it. Takes
   // snapshot this table, and it is also the normal next state.
   always_comb begin
      busy_upd = busy_q;
      for (int r = 0; r < REG_N; r++) begin
         tag_upd[r] = tag_q[r];
      end
      if (commit_hit) begin
         busy_upd[commit_rd] = 1'b0;
      end
      if (issue_ok) begin
         busy_upd[issue_rd] = 1'b1;
         tag_upd[issue_rd]  = issue_tag;
      end
   end

   // Lookup ports read the current registered state. A lookup that names
   // the register whose producer is retiring this cycle gets the retiring
   // value directly, so the consumer does not wait a cycle for the write.
   for (genvar k = 0; k < RD_PORTS; k++) begin : g_lookup
      logic [REG_W-1:0] rs;
      logic             byp;
      assign rs  = q_rs[k*REG_W +: REG_W];
      assign byp = commit_hit && (rs == commit_rd);
      assign q_val[k*DATA_W +: DATA_W] = byp ? commit_val : val_q[rs];
      assign q_busy[k]                 = byp ? 1'b0 : busy_q[rs];
      assign q_tag[k*ROB_W +: ROB_W]   = byp ? '0 : tag_q[rs];
   end

   // Architectural state. A commit writes its value even during a flush or
   // a restore, because a retired result is final. Only the busy/tag table
   // is rewound. Rollback beats restore, and restore beats a normal update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= '0;
         for (int r = 0; r < REG_N; r++) begin
            val_q[r] <= '0;
            tag_q[r] <= '0;
         end
      end else if (rdy) begin
         if (commit_ok) begin
            val_q[commit_rd] <= commit_val;
         end
         if (rollback) begin
            busy_q <= '0;
         end else if (restore_ok) begin
            busy_q <= rest_busy;
            for (int r = 0; r < REG_N; r++) begin
               tag_q[r] <= rest_tag[r];
            end
         end else begin
            busy_q <= busy_upd;
            for (int r = 0; r < REG_N; r++) begin
               tag_q[r] <= tag_upd[r];
            end
         end
      end
   end

`ifdef RENAME_RF_CKPT_EN
   logic [REG_N-1:0] snap_busy [CKPT_N];
   logic [ROB_W-1:0] snap_tag  [CKPT_N][REG_N];
   logic [CK_W-1:0]  head_q;
   logic [CK_W-1:0]  tail_q;
   logic [CK_W:0]    count_q;
   logic [CK_W:0]    count_n;
   logic [CK_W:0]    rest_dist;
   logic             full_q;
   logic             take_ok;
   logic             release_ok;

   function automatic logic [CK_W-1:0] ck_inc(input logic [CK_W-1:0] p);
      return (p == CK_W'(CKPT_N - 1)) ? '0 : p + 1'b1;
   endfunction

   // rest_dist is the number of live checkpoints older than the requested
   // one. The requested id is live only if that number is less than the
   // live count. After the restore, that number becomes the new count.
   always_comb begin
      if (ckpt_restore_id >= head_q) begin
         rest_dist = {1'b0, ckpt_restore_id} - {1'b0, head_q};
      end else begin
         rest_dist = {1'b0, ckpt_restore_id} + (CK_W+1)'(CKPT_N) - {1'b0, head_q};
      end
   end

   assign restore_ok = ckpt_restore && ({1'b0, ckpt_restore_id} < (CK_W+1)'(CKPT_N))
                       && (rest_dist < count_q);
   assign take_ok    = ckpt_take && (count_q != (CK_W+1)'(CKPT_N));
   assign release_ok = ckpt_release && (count_q != '0);

   // If a take and a release happen together, the count stays the same.
   // When the buffer is full, the take is refused but the release still
   // happens.
   always_comb begin
      count_n = count_q;
      if (take_ok && !release_ok) begin
         count_n = count_q + 1'b1;
      end else if (!take_ok && release_ok) begin
         count_n = count_q - 1'b1;
      end
   end

   // The restored table is the snapshot, minus any producer that retires in
   // this same cycle.
   always_comb begin
      rest_busy = snap_busy[ckpt_restore_id];
      for (int r = 0; r < REG_N; r++) begin
         rest_tag[r] = snap_tag[ckpt_restore_id][r];
      end
      if (commit_ok && rest_busy[commit_rd] && (rest_tag[commit_rd] == commit_tag)) begin
         rest_busy[commit_rd] = 1'b0;
      end
   end

   // Checkpoint ring. Commit clears are applied to every slot. A dead slot
   // is always overwritten by a take before anything can restore it, so
   // clearing it does no harm. A take into slot tail_q comes later in this
   // block and wins over any clear to the same slot. Restore drops the
   // same-cycle take and release, and frees the restored slot and every
   // younger slot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else if (rdy) begin
         for (int s = 0; s < CKPT_N; s++) begin
            if (commit_ok && snap_busy[s][commit_rd] && (snap_tag[s][commit_rd] == commit_tag)) begin
               snap_busy[s][commit_rd] <= 1'b0;
            end
         end
         if (rollback) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
         end else if (restore_ok) begin
            tail_q  <= ckpt_restore_id;
            count_q <= rest_dist;
            full_q  <= 1'b0;
         end else begin
            if (take_ok) begin
               snap_busy[tail_q] <= busy_upd;
               for (int r = 0; r < REG_N; r++) begin
                  snap_tag[tail_q][r] <= tag_upd[r];
               end
               tail_q <= ck_inc(tail_q);
            end
            if (release_ok) begin
               head_q <= ck_inc(head_q);
            end
            count_q <= count_n;
            full_q  <= (count_n == (CK_W+1)'(CKPT_N));
         end
      end
   end

   assign ckpt_id   = tail_q;
   assign ckpt_full = full_q;
`else
   logic ckpt_unused;

   // Without checkpoints, recovery is by rollback only and the ckpt
   // outputs stay at zero.
   assign restore_ok  = 1'b0;
   assign rest_busy   = '0;
   for (genvar r = 0; r < REG_N; r++) begin : g_no_rest
      assign rest_tag[r] = '0;
   end
   assign ckpt_unused = ^{ckpt_take, ckpt_release, ckpt_restore, ckpt_restore_id};
   assign ckpt_id     = '0;
   assign ckpt_full   = 1'b0;
`endif

endmodule

// File: tb/tb_rename_regfile.sv
// ---------------------------------------------------------------------------
// tb_rename_regfile
//
// Scoreboard bench for rename_regfile. The driver applies one stimulus
// vector per cycle at the falling edge. It pushes the lookup and ckpt
// outputs that the reference model predicts for that vector, then advances
// the model. The model is a set of plain arrays plus a queue of live
// checkpoints. A monitor pops each prediction shortly after the inputs
// settle and compares it with the DUT outputs. Directed scenarios come
// first, then a long randomized run.
// ---------------------------------------------------------------------------
module tb_rename_regfile;

   localparam int DATA_W   = 16;
   localparam int REG_N    = 8;
   localparam int ROB_W    = 3;
   localparam int RD_PORTS = 2;
   localparam int CKPT_N   = 4;
   localparam int REG_W    = $clog2(REG_N);
   localparam int CK_W     = $clog2(CKPT_N);

`ifdef RENAME_RF_CKPT_EN
   localparam bit CkEn = 1'b1;
`else
   localparam bit CkEn = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic                       rdy = 1'b0;
   logic                       rollback = 1'b0;
   logic [RD_PORTS*REG_W-1:0]  q_rs = '0;
   logic [RD_PORTS*DATA_W-1:0] q_val;
   logic [RD_PORTS-1:0]        q_busy;
   logic [RD_PORTS*ROB_W-1:0]  q_tag;
   logic                       issue = 1'b0;
   logic [REG_W-1:0]           issue_rd = '0;
   logic [ROB_W-1:0]           issue_tag = '0;
   logic                       commit = 1'b0;
   logic [REG_W-1:0]           commit_rd = '0;
   logic [DATA_W-1:0]          commit_val = '0;
   logic [ROB_W-1:0]           commit_tag = '0;
   logic                       ckpt_take = 1'b0;
   logic                       ckpt_release = 1'b0;
   logic                       ckpt_restore = 1'b0;
   logic [CK_W-1:0]            ckpt_restore_id = '0;
   logic [CK_W-1:0]            ckpt_id;
   logic                       ckpt_full;

   rename_regfile #(
      .DATA_W(DATA_W), .REG_N(REG_N), .ROB_W(ROB_W),
      .RD_PORTS(RD_PORTS), .CKPT_N(CKPT_N)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .q_rs(q_rs), .q_val(q_val), .q_busy(q_busy), .q_tag(q_tag),
      .issue(issue), .issue_rd(issue_rd), .issue_tag(issue_tag),
      .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_tag(commit_tag),
      .ckpt_take(ckpt_take), .ckpt_release(ckpt_release),
      .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
      .ckpt_id(ckpt_id), .ckpt_full(ckpt_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                      rst_n;
      logic                      rdy;
      logic                      rollback;
      logic [RD_PORTS*REG_W-1:0] rs;
      logic                      issue;
      logic [REG_W-1:0]          issue_rd;
      logic [ROB_W-1:0]          issue_tag;
      logic                      commit;
      logic [REG_W-1:0]          commit_rd;
      logic [DATA_W-1:0]         commit_val;
      logic [ROB_W-1:0]          commit_tag;
      logic                      take;
      logic                      rel;
      logic                      restore;
      logic [CK_W-1:0]           restore_id;
   } stim_t;

   typedef struct {
      logic [RD_PORTS*DATA_W-1:0] val;
      logic [RD_PORTS-1:0]        busy;
      logic [RD_PORTS*ROB_W-1:0]  tag;
      logic [CK_W-1:0]            id;
      logic                       full;
   } exp_t;

   typedef struct {
      logic [CK_W-1:0]             id;
      logic [REG_N-1:0]            busy;
      logic [REG_N-1:0][ROB_W-1:0] tag;
   } snap_t;

   // Reference model state
   logic [DATA_W-1:0]           m_val [REG_N];
   logic [REG_N-1:0]            m_busy;
   logic [REG_N-1:0][ROB_W-1:0] m_tag;
   snap_t                       m_ck [$];
   int                          m_tail = 0;
   bit                          m_known = 1'b0;

   exp_t exp_q [$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic stim_t idle(input logic [REG_W-1:0] r);
      stim_t s;
      s = '{default: '0};
      s.rst_n = 1'b1;
      s.rdy   = 1'b1;
      for (int k = 0; k < RD_PORTS; k++) s.rs[k*REG_W +: REG_W] = r;
      return s;
   endfunction

   // Outputs predicted from the state before the edge: stored values,
   // plus the retiring value for a register whose named producer commits.
   function automatic exp_t modelLookup(input stim_t s);
      exp_t             e;
      logic [REG_W-1:0] r;
      bit               hit;
      hit = s.commit && (s.commit_rd != 0) && m_busy[s.commit_rd]
            && (m_tag[s.commit_rd] == s.commit_tag);
      for (int k = 0; k < RD_PORTS; k++) begin
         r = s.rs[k*REG_W +: REG_W];
         if (hit && r == s.commit_rd) begin
            e.val[k*DATA_W +: DATA_W] = s.commit_val;
            e.busy[k]                 = 1'b0;
            e.tag[k*ROB_W +: ROB_W]   = '0;
         end else begin
            e.val[k*DATA_W +: DATA_W] = m_val[r];
            e.busy[k]                 = m_busy[r];
            e.tag[k*ROB_W +: ROB_W]   = m_tag[r];
         end
      end
      e.id   = CK_W'(m_tail);
      e.full = (m_ck.size() == CKPT_N);
      return e;
   endfunction

   task automatic modelStep(input stim_t s);
      bit    hit;
      int    idx;
      int    pre;
      snap_t t;
      if (!s.rst_n) begin
         for (int r = 0; r < REG_N; r++) m_val[r] = '0;
         m_busy  = '0;
         m_tag   = '0;
         m_ck.delete();
         m_tail  = 0;
         m_known = 1'b1;
         return;
      end
      if (!s.rdy) return;
      hit = s.commit && (s.commit_rd != 0) && m_busy[s.commit_rd]
            && (m_tag[s.commit_rd] == s.commit_tag);
      if (s.commit && s.commit_rd != 0) begin
         m_val[s.commit_rd] = s.commit_val;
         for (int i = 0; i < m_ck.size(); i++) begin
            t = m_ck[i];
            if (t.busy[s.commit_rd] && t.tag[s.commit_rd] == s.commit_tag) begin
               t.busy[s.commit_rd] = 1'b0;
               m_ck[i] = t;
            end
         end
      end
      idx = -1;
      if (CkEn && s.restore) begin
         for (int i = 0; i < m_ck.size(); i++) if (m_ck[i].id == s.restore_id) idx = i;
      end
      if (s.rollback) begin
         m_busy = '0;
         m_ck.delete();
         m_tail = 0;
      end else if (idx >= 0) begin
         m_busy = m_ck[idx].busy;
         m_tag  = m_ck[idx].tag;
         while (m_ck.size() > idx) void'(m_ck.pop_back());
         m_tail = int'(s.restore_id);
      end else begin
         if (hit) m_busy[s.commit_rd] = 1'b0;
         if (s.issue && s.issue_rd != 0) begin
            m_busy[s.issue_rd] = 1'b1;
            m_tag[s.issue_rd]  = s.issue_tag;
         end
         if (CkEn) begin
            pre = m_ck.size();
            if (s.rel && pre > 0) void'(m_ck.pop_front());
            if (s.take && pre < CKPT_N) begin
               t.id   = CK_W'(m_tail);
               t.busy = m_busy;
               t.tag  = m_tag;
               m_ck.push_back(t);
               m_tail = (m_tail + 1) % CKPT_N;
            end
         end
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      rst             = s.rst_n;
      rdy             = s.rdy;
      rollback        = s.rollback;
      q_rs            = s.rs;
      issue           = s.issue;
      issue_rd        = s.issue_rd;
      issue_tag       = s.issue_tag;
      commit          = s.commit;
      commit_rd       = s.commit_rd;
      commit_val      = s.commit_val;
      commit_tag      = s.commit_tag;
      ckpt_take       = s.take;
      ckpt_release    = s.rel;
      ckpt_restore    = s.restore;
      ckpt_restore_id = s.restore_id;
      if (m_known) exp_q.push_back(modelLookup(s));
      modelStep(s);
   endtask

   task automatic checkOutput(input exp_t e);
      vectors++;
      if (q_val !== e.val) begin
         miscompares++;
         $display("[TB] FAIL q_val vec %0d: got %h, expected %h", vectors, q_val, e.val);
      end
      if (q_busy !== e.busy) begin
         miscompares++;
         $display("[TB] FAIL q_busy vec %0d: got %b, expected %b", vectors, q_busy, e.busy);
      end
      if (q_tag !== e.tag) begin
         miscompares++;
         $display("[TB] FAIL q_tag vec %0d: got %h, expected %h", vectors, q_tag, e.tag);
      end
      if (ckpt_id !== e.id) begin
         miscompares++;
         $display("[TB] FAIL ckpt_id vec %0d: got %0d, expected %0d", vectors, ckpt_id, e.id);
      end
      if (ckpt_full !== e.full) begin
         miscompares++;
         $display("[TB] FAIL ckpt_full vec %0d: got %b, expected %b", vectors, ckpt_full, e.full);
      end
   endtask

   // Monitor: compares each queued prediction once the inputs have settled,
   // well before the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      stim_t s;

      // Reset, then confirm that everything reads as zero
      s = idle('0); s.rst_n = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
      s = idle(3'd5); applyStimulus(s);

      // Rename of rd 5, lookup, then a bypassed commit
      s = idle(3'd5); s.issue = 1; s.issue_rd = 3'd5; s.issue_tag = 3'd3; applyStimulus(s);
      s = idle(3'd5); applyStimulus(s);
      s = idle(3'd5); s.commit = 1; s.commit_rd = 3'd5; s.commit_tag = 3'd3;
      s.commit_val = 16'h00AB; applyStimulus(s);
      s = idle(3'd5); applyStimulus(s);

      // A stale commit writes the value but leaves the newer rename busy
      s = idle(3'd7); s.issue = 1; s.issue_rd = 3'd7; s.issue_tag = 3'd2; applyStimulus(s);
      s = idle(3'd7); s.issue = 1; s.issue_rd = 3'd7; s.issue_tag = 3'd6; applyStimulus(s);
      s = idle(3'd7); s.commit = 1; s.commit_rd = 3'd7; s.commit_tag = 3'd2;
      s.commit_val = 16'h0011; applyStimulus(s);
      s = idle(3'd7); applyStimulus(s);

      // Register 0 ignores issue and commit
      s = idle('0); s.issue = 1; s.issue_rd = '0; s.issue_tag = 3'd5;
      s.commit = 1; s.commit_rd = '0; s.commit_val = 16'hFFFF; applyStimulus(s);
      s = idle('0); applyStimulus(s);

      // Checkpoint, rename again, retire the old producer, restore
      s = idle(3'd3); s.issue = 1; s.issue_rd = 3'd3; s.issue_tag = 3'd1; applyStimulus(s);
      s = idle(3'd3); s.take = 1; applyStimulus(s);
      s = idle(3'd3); s.issue = 1; s.issue_rd = 3'd3; s.issue_tag = 3'd4; applyStimulus(s);
      s = idle(3'd3); s.commit = 1; s.commit_rd = 3'd3; s.commit_tag = 3'd1;
      s.commit_val = 16'h0033; applyStimulus(s);
      s = idle(3'd3); s.restore = 1; s.restore_id = '0; applyStimulus(s);
      s = idle(3'd3); applyStimulus(s);

      // Fill the buffer, then a take and a release together
      for (int i = 0; i < CKPT_N; i++) begin
         s = idle(3'(i)); s.take = 1; applyStimulus(s);
      end
      s = idle('0); s.take = 1; s.rel = 1; applyStimulus(s);
      s = idle('0); applyStimulus(s);

      // Rollback beats a same-cycle restore and issue
      s = idle(3'd2); s.issue = 1; s.issue_rd = 3'd2; s.issue_tag = 3'd5; applyStimulus(s);
      s = idle(3'd2); s.rollback = 1; s.restore = 1; s.restore_id = '0;
      s.issue = 1; s.issue_rd = 3'd4; s.issue_tag = 3'd1; applyStimulus(s);
      s = idle(3'd4); applyStimulus(s);

      // Reset in the middle of activity
      s = idle(3'd6); s.issue = 1; s.issue_rd = 3'd6; s.issue_tag = 3'd7; s.take = 1; applyStimulus(s);
      s = idle(3'd6); s.commit = 1; s.commit_rd = 3'd1; s.commit_val = 16'h5A5A; applyStimulus(s);
      s = idle(3'd6); s.rst_n = 1'b0; s.issue = 1; s.issue_rd = 3'd2; applyStimulus(s);
      s = idle(3'd6); applyStimulus(s);

      // Randomized traffic, biased toward collisions and tag matches
      for (int n = 0; n < 1500; n++) begin
         s = idle('0);
         s.rst_n      = ($urandom_range(0, 199) != 0);
         s.rdy        = ($urandom_range(0, 7) != 0);
         s.rollback   = ($urandom_range(0, 49) == 0);
         s.issue      = ($urandom_range(0, 1) == 1);
         s.issue_rd   = REG_W'($urandom_range(0, REG_N - 1));
         s.issue_tag  = ROB_W'($urandom);
         s.commit     = s.rdy && ($urandom_range(0, 1) == 1);
         s.commit_rd  = REG_W'($urandom_range(0, REG_N - 1));
         s.commit_tag = ($urandom_range(0, 2) != 0) ? m_tag[s.commit_rd] : ROB_W'($urandom);
         s.commit_val = DATA_W'($urandom);
         s.take       = ($urandom_range(0, 3) == 0);
         s.restore    = ($urandom_range(0, 9) == 0);
         s.rel        = !s.restore && ($urandom_range(0, 5) == 0);
         s.restore_id = CK_W'($urandom);
         for (int k = 0; k < RD_PORTS; k++) begin
            s.rs[k*REG_W +: REG_W] = ($urandom_range(0, 2) == 0) ? s.commit_rd
                                                                : REG_W'($urandom);
         end
         applyStimulus(s);
      end

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d predictions pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register value width.
REQ-002 SHALL provide parameter REG_N, default 32, meaning architectural register count; REG_W = $clog2(REG_N).
REQ-003 SHALL provide parameter ROB_W, default 4, meaning ROB position (rename tag) width.
REQ-004 SHALL provide parameter RD_PORTS, default 2, meaning number of independent source lookup ports.
REQ-005 SHALL provide parameter CKPT_N, default 4, meaning branch checkpoint slots; CK_W = $clog2(CKPT_N).
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-low.
- rdy  in  1  global enable; 0 = all state holds.
- rollback  in  1  full flush.
- q_rs  in  RD_PORTS*REG_W  flattened lookup indices; port k at bits [k*REG_W +: REG_W].
- q_val  out  RD_PORTS*DATA_W  lookup values.
- q_busy  out  RD_PORTS  1 = renamed.
- q_tag  out  RD_PORTS*ROB_W  producing ROB position.
- issue  in  1; issue_rd  in  REG_W; issue_tag  in  ROB_W  rename rd to tag.
- commit  in  1; commit_rd  in  REG_W; commit_val  in  DATA_W; commit_tag  in  ROB_W  retire.
- ckpt_take  in  1  snapshot rename table.
- ckpt_release  in  1  free oldest checkpoint (branch resolved correct).
- ckpt_restore  in  1; ckpt_restore_id  in  CK_W  mispredict recovery.
- ckpt_id  out  CK_W  id the next take receives (registered).
- ckpt_full  out  1  all slots live (registered).

Function
REQ-007 Lookups SHALL be combinational, reflecting state before same-cycle issue.
REQ-008 Lookup bypass SHALL apply: commit, commit_rd!=0, busy[commit_rd], tag[commit_rd]==commit_tag, q_rs==commit_rd -> q_val=commit_val, q_busy=0, q_tag=0.
REQ-009 Register 0 SHALL read val 0, busy 0, tag 0; issue/commit to rd 0 ignored.
REQ-010 Commit SHALL write val[rd] unconditionally; clear busy[rd] only on tag match.
REQ-011 Issue SHALL set busy[rd]=1, tag[rd]=issue_tag next cycle; issue beats commit clear on same rd.
REQ-012 Take SHALL store post-update busy/tag table (this cycle's issue and commit applied) into slot ckpt_id; tail and count advance, wrapping modulo CKPT_N.
REQ-013 Commit SHALL also clear busy in every live snapshot whose entry for commit_rd holds a matching tag.
REQ-014 Restore SHALL load busy/tag from slot ckpt_restore_id (same-cycle commit clear applied); values unchanged; tail <= ckpt_restore_id; that slot and all younger freed.
REQ-015 Release SHALL advance head, decrement count; ignored when count==0.
REQ-016 Take while ckpt_full SHALL be ignored, even with simultaneous release; otherwise take+release same cycle both occur, count unchanged.
REQ-017 Priority SHALL be rollback > restore > issue/take; rollback clears all busy and frees all slots; restore drops same-cycle issue and take.
REQ-018 Restore of a non-live id SHALL be ignored.
REQ-019 rdy=0 SHALL freeze all state; lookups remain valid.

Reset
REQ-020 rst==0 at clk edge SHALL zero all val, busy, tag, head, tail, count; ckpt_id=0, ckpt_full=0; reset beats rdy.
REQ-021 Reset mid-operation SHALL discard all live checkpoints.

Configuration
REQ-022 Macro RENAME_RF_CKPT_EN defined: checkpoint logic per REQ-012..018 present.
REQ-023 Macro absent: no snapshot storage; ckpt_* inputs ignored; ckpt_id=0, ckpt_full=0; recovery by rollback only.

Verification
REQ-024 issue rd=5 tag=3; next cycle lookup 5 -> busy=1, tag=3; commit rd=5 tag=3 val=0xAB same cycle -> q_val=0xAB, busy=0.
REQ-025 issue rd=7 tag=2, then issue rd=7 tag=6; commit rd=7 tag=2 val=0x11 -> val[7]=0x11, busy=1, tag=6.
REQ-026 issue rd=3 tag=1; take (id 0); issue rd=3 tag=4; commit rd=3 tag=1; restore id 0 -> rd 3 busy=0, ckpt_id=0.
REQ-027 CKPT_N takes -> ckpt_full=1; extra take+release -> count CKPT_N-1, ckpt_full=0.
REQ-028 rollback with restore+issue same cycle -> all busy=0, count=0; rst=0 mid-run -> all outputs zero next cycle.
